uart_rx: RTL

- UART receiver for YetAnotherUART; mirror of the transmit path, same frame format and configuration set.
- Oversamples the serial input with the programmed bit length and validates start, parity and stop bits.
- Pushes each received byte plus error flags to the RX FIFO through a one-cycle valid pulse.
- Drives RTS from RX FIFO fullness when hardware flow control is enabled.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-to-RX-FIFO bundle and stop bit mode encoding
typedef enum logic [1:0] {
   HALF_PERIOD          = 2'd0,
   ONE_PERIOD           = 2'd1,
   ONE_AND_HALF_PERIODS = 2'd2,
   TWO_PERIODS          = 2'd3
} stop_bit_mode_t;

interface uart_rx_if;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_overflow;
   logic       i_fifo_full;

   modport master (
      output o_valid, o_data, o_parity_err, o_frame_err, o_overflow,
      input  i_fifo_full
   );

   modport slave (
      input  o_valid, o_data, o_parity_err, o_frame_err, o_overflow,
      output i_fifo_full
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - YetAnotherUART receiver: oversampled frame decode into the RX FIFO
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic           i_clk,
   input  logic           i_nrst,
   input  logic           i_rx,
   uart_rx_if.master      fifo,
   output logic           o_rts,
   output logic           o_rx_status,
   output logic           o_rx_started,
   input  logic           i_hw_flow_control_enable,
   input  logic           i_parity_enable,
   input  stop_bit_mode_t i_stop_bit_mode,
   input  logic [1:0]     i_stop_bit_value,
   input  logic [31:0]    i_bit_length,
   input  logic           i_msb_first
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
   } state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s, rx_q, fall;

   logic [31:0]    cfg_len;
   stop_bit_mode_t cfg_mode;
   logic [1:0]     cfg_stop;
   logic           cfg_par, cfg_msb;

   logic [31:0] cnt, target;
   logic        tick, stop_miss;
   logic [2:0]  bit_idx;
   logic [7:0]  frame, frame_rev;
   logic        par_err, frm_err;
   logic [7:0]  data_q;
   logic        perr_q, ferr_q;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         sync <= '1;
         rx_q <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], i_rx};
         rx_q <= rx_s;
      end
   end

   assign rx_s = sync[SYNC_STAGES-1];
   assign fall = rx_q & ~rx_s;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cfg_len  <= '0;
         cfg_mode <= HALF_PERIOD;
         cfg_stop <= '0;
         cfg_par  <= 1'b0;
         cfg_msb  <= 1'b0;
      end else if (state == S_IDLE) begin
         cfg_len  <= i_bit_length;
         cfg_mode <= i_stop_bit_mode;
         cfg_stop <= i_stop_bit_value;
         cfg_par  <= i_parity_enable;
         cfg_msb  <= i_msb_first;
      end
   end

   // Samples use rx_q, the copy one clock behind rx_s, so a counter that clears
   // on START entry lines up with the edge-detect cycle; this keeps P=1 exact.
   always_comb begin
      target = cfg_len;
      if (state == S_START)
         target = cfg_len >> 1;
      else if (state == S_STOP1 && cfg_mode == HALF_PERIOD)
         target = (cfg_len >> 1) + (cfg_len >> 2);
   end

   assign tick      = (cnt == target);
   assign stop_miss = rx_q != ((state == S_STOP2) ? cfg_stop[1] : cfg_stop[0]);

   always_comb begin
      frame_rev = '0;
      for (int i = 0; i < 8; i++)
         frame_rev[i] = frame[7-i];
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (fall) state_nx = S_START;
         S_START:  if (tick) state_nx = rx_q ? S_IDLE : S_DATA;
         S_DATA:   if (tick && bit_idx == 3'd7) state_nx = cfg_par ? S_PARITY : S_STOP1;
         S_PARITY: if (tick) state_nx = S_STOP1;
         S_STOP1:  if (tick) state_nx = (cfg_mode == TWO_PERIODS) ? S_STOP2 : S_DONE;
         S_STOP2:  if (tick) state_nx = S_DONE;
         S_DONE:   state_nx = fall ? S_START : S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      o_rx_status  = (state != S_IDLE);
      o_rx_started = (state == S_START) && tick && !rx_q;
      fifo.o_valid    = (state == S_DONE);
      fifo.o_overflow = (state == S_DONE) && fifo.i_fifo_full;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         if (state == S_IDLE || state_nx != state || tick)
            cnt <= '0;
         else
            cnt <= cnt + 32'd1;

         if (state == S_START) begin
            bit_idx <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
         end
         if (state == S_DATA && tick) begin
            frame   <= {rx_q, frame[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == S_PARITY && tick)
            par_err <= rx_q ^ (^frame);
         if ((state == S_STOP1 || state == S_STOP2) && tick)
            frm_err <= frm_err | stop_miss;

         // Output registers load on the final stop sample and then hold.
         if (state_nx == S_DONE && state != S_DONE) begin
            data_q <= cfg_msb ? frame_rev : frame;
            perr_q <= par_err;
            ferr_q <= frm_err | stop_miss;
         end
      end
   end

   assign fifo.o_data       = data_q;
   assign fifo.o_parity_err = perr_q;
   assign fifo.o_frame_err  = ferr_q;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst)
         o_rts <= 1'b1;
      else
         o_rts <= i_hw_flow_control_enable ? !fifo.i_fifo_full : 1'b1;
   end

endmodule
